semi4_gen: RTL and testbench
============================

Name: semi4_gen

Overview:
- Semigraphics-4 pattern generator for the 6847 replacement.
- Latches one display byte per character slot and tracks the scan row within the 12-row character cell.
- Produces the 8-pixel row pattern and the colour index consumed directly by the semigraphics select stage (S4Data/S4Colour inputs).
- Sits between the video RAM fetch logic and the semigraphics select stage.

Parameters:
ROWS_PER_CHAR, 12, scan rows per character cell; row counter wraps after ROWS_PER_CHAR-1
SPLIT_ROW, 6, first row of the lower quadrant pair (rows 0..SPLIT_ROW-1 are the upper half)

Ports:
Clk  input  1  pixel-domain clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
CharLoad  input  1  one-cycle strobe: VData holds the current character byte
VData  input  8  display byte; bit7=1 semigraphics, [6:4] colour, [3:0] quadrants (3=UL, 2=UR, 1=LL, 0=LR)
HSync  input  1  horizontal sync; rising edge advances the cell row
FSync  input  1  field sync; level-high clears the cell row
S4Data  output  8  pixel pattern for current character row, MSB = leftmost pixel
S4Colour  output  4  colour index {1'b0, VData[6:4]}
S4Valid  output  1  one-cycle pulse: S4Data/S4Colour updated this cycle
Row  output  4  current cell row 0..ROWS_PER_CHAR-1 (debug/downstream alignment)

Behaviour:
- Reset (synchronous, active-high): S4Data=8'h00, S4Colour=4'h0, S4Valid=0, Row=0, HSync edge register=0. Reset overrides all other inputs in the same cycle.
- HSync edge detect: register HSync each cycle; edge = HSync & ~HSync_q.
- Row counter:
  - FSync=1: Row<=0. FSync has priority over the HSync edge.
  - Otherwise, on HSync edge: Row<=Row+1, wrapping from ROWS_PER_CHAR-1 to 0.
  - Otherwise: hold.
  - Row values >= ROWS_PER_CHAR are unreachable; if forced, the next edge wraps to 0.
- Pattern latch (latency 1): CharLoad=1 in cycle n -> S4Data, S4Colour updated and S4Valid=1 in cycle n+1.
  - Row sampled is the pre-update value in cycle n, including when an HSync edge or FSync coincides with CharLoad.
- Pattern rule for VData[7]=1:
  - Row < SPLIT_ROW: S4Data = {4{VData[3]}, 4{VData[2]}}.
  - Row >= SPLIT_ROW: S4Data = {4{VData[1]}, 4{VData[0]}}.
  - S4Colour = {1'b0, VData[6:4]}.
- VData[7]=0 (alphanumeric byte): S4Data=8'h00, S4Colour=4'h0, S4Valid still pulses.
- No CharLoad: S4Data/S4Colour hold their last value; S4Valid=0.
- Back-to-back CharLoad on consecutive cycles: each produces its own update and valid pulse; no stall, no backpressure.
- Reset mid-line: outputs clear next edge; any CharLoad in the reset cycle is discarded.

Optional Feature:
- Macro SEMI4_BLANK_EN.
- Defined: adds input port DispEn (1 bit). When CharLoad=1 and DispEn=0, the latched result is forced to S4Data=8'h00, S4Colour=4'h0; S4Valid still pulses. The row counter is unaffected by DispEn.
- Undefined: no DispEn port; every CharLoad produces a pattern per the rules above.

Decomposition:
- Shared package vdg_pkg:
  - ROWS_PER_CHAR and SPLIT_ROW defaults.
  - Row width constant (4).
  - Colour-index constants (green..orange, 0-7).
  - Byte field positions: semigraphics flag bit 7, colour [6:4], quadrants [3:0].
- One sub-module: char_row_counter (HSync edge detect + FSync clear + wrap), reused by the alphanumeric generator.
- Pattern expansion and output registers stay in semi4_gen.

Test Plan:
1. Reset=1 for 2 cycles with CharLoad=1, VData=8'hFF -> S4Data=00, S4Colour=0, S4Valid=0, Row=0 throughout.
2. FSync pulse, Row=0, CharLoad with VData=8'hB9 (colour 3, quads 1001) -> next cycle S4Data=8'hF0, S4Colour=4'h3, S4Valid=1 for exactly one cycle.
3. Six HSync rising edges (Row=6), CharLoad VData=8'hB9 -> S4Data=8'h0F; a held-high HSync produces no extra increments.
4. Twelve HSync edges from Row=0 -> Row returns to 0; FSync=1 together with an HSync edge at Row=5 -> Row=0.
5. CharLoad coincident with the HSync edge at Row=5, VData=8'h8C -> pattern uses Row 5: S4Data=8'hFF, S4Colour=0; Row=6 afterwards.
6. CharLoad VData=8'h4F (bit7=0) -> S4Data=00, S4Colour=0, S4Valid=1; with SEMI4_BLANK_EN, DispEn=0 and VData=8'hFF -> S4Data=00, S4Colour=0.

Source files
------------

// File: rtl/vdg_pkg.sv
// Shared constants for the 6847 replacement video generators.
// Holds cell geometry defaults, the row counter width, the colour index
// names and the bit positions of the fields inside a display byte.
package vdg_pkg;

    // Character cell geometry
    localparam int ROWS_PER_CHAR_DEF = 12;
    localparam int SPLIT_ROW_DEF     = 6;
    localparam int ROW_W             = 4;

    // Colour indices as produced on the colour output
    localparam logic [2:0] COL_GREEN   = 3'd0;
    localparam logic [2:0] COL_YELLOW  = 3'd1;
    localparam logic [2:0] COL_BLUE    = 3'd2;
    localparam logic [2:0] COL_RED     = 3'd3;
    localparam logic [2:0] COL_BUFF    = 3'd4;
    localparam logic [2:0] COL_CYAN    = 3'd5;
    localparam logic [2:0] COL_MAGENTA = 3'd6;
    localparam logic [2:0] COL_ORANGE  = 3'd7;

    // Display byte field positions
    localparam int SG_FLAG_BIT = 7;
    localparam int COL_MSB     = 6;
    localparam int COL_LSB     = 4;
    localparam int QUAD_MSB    = 3;
    localparam int QUAD_LSB    = 0;

    // Quadrant positions inside the 4-bit quadrant field
    localparam int QUAD_UL = 3;
    localparam int QUAD_UR = 2;
    localparam int QUAD_LL = 1;
    localparam int QUAD_LR = 0;

    // Expand the quadrant nibble into one 8-pixel row: left half then right half
    function automatic logic [7:0] expand_quads(input logic [3:0] quads,
                                                input logic       upper);
        if (upper)
            expand_quads = {{4{quads[QUAD_UL]}}, {4{quads[QUAD_UR]}}};
        else
            expand_quads = {{4{quads[QUAD_LL]}}, {4{quads[QUAD_LR]}}};
    endfunction

endpackage

// File: rtl/char_row_counter.sv
// Scan row counter within a character cell.
// Advances on each rising edge of hsync, clears while fsync is high and
// wraps after ROWS_PER_CHAR-1. Shared by the semigraphics and
// alphanumeric generators so both stay row-aligned.
module char_row_counter
    import vdg_pkg::*;
#(
    parameter int ROWS_PER_CHAR = ROWS_PER_CHAR_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync,
    input  logic             fsync,
    output logic [ROW_W-1:0] row
);

    logic hsync_q;
    logic hsync_edge;

    assign hsync_edge = hsync & ~hsync_q;

    // Sync edge register and row count; field sync wins over a line edge, and
    // any out-of-range value falls back to 0 on the next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= 1'b0;
            row     <= '0;
        end else begin
            hsync_q <= hsync;
            if (fsync)
                row <= '0;
            else if (hsync_edge) begin
                if (row >= ROW_W'(ROWS_PER_CHAR - 1))
                    row <= '0;
                else
                    row <= row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/semi4_gen.sv
// Semigraphics-4 pattern generator.
// Latches one display byte per character slot and turns it into the 8-pixel
// row pattern and colour index for the current scan row of the cell.
// Optional macro SEMI4_BLANK_EN adds a DispEn input that blanks the latched
// result while display is disabled.
module semi4_gen
    import vdg_pkg::*;
#(
    parameter int ROWS_PER_CHAR = ROWS_PER_CHAR_DEF,
    parameter int SPLIT_ROW     = SPLIT_ROW_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CharLoad,
    input  logic [7:0]       VData,
    input  logic             HSync,
    input  logic             FSync,
`ifdef SEMI4_BLANK_EN
    input  logic             DispEn,
`endif
    output logic [7:0]       S4Data,
    output logic [3:0]       S4Colour,
    output logic             S4Valid,
    output logic [ROW_W-1:0] Row
);

    logic       disp_ok;
    logic [7:0] next_data;
    logic [3:0] next_colour;

`ifdef SEMI4_BLANK_EN
    assign disp_ok = DispEn;
`else
    assign disp_ok = 1'b1;
`endif

    char_row_counter #(
        .ROWS_PER_CHAR(ROWS_PER_CHAR)
    ) u_row (
        .clk   (Clk),
        .reset (Reset),
        .hsync (HSync),
        .fsync (FSync),
        .row   (Row)
    );

    // Build the pattern from the byte and the row as it stands before this edge;
    // alphanumeric or blanked bytes produce an empty cell
    always_comb begin
        next_data   = 8'h00;
        next_colour = 4'h0;
        if (VData[SG_FLAG_BIT] && disp_ok) begin
            next_data   = expand_quads(VData[QUAD_MSB:QUAD_LSB],
                                       Row < ROW_W'(SPLIT_ROW));
            next_colour = {1'b0, VData[COL_MSB:COL_LSB]};
        end
    end

    // Output registers: update and flag valid one cycle after each load
    always_ff @(posedge Clk) begin
        if (Reset) begin
            S4Data   <= 8'h00;
            S4Colour <= 4'h0;
            S4Valid  <= 1'b0;
        end else begin
            S4Valid <= CharLoad;
            if (CharLoad) begin
                S4Data   <= next_data;
                S4Colour <= next_colour;
            end
        end
    end

endmodule

// File: tb/tb_semi4_gen.sv
// Directed self-checking bench for semi4_gen.
module tb_semi4_gen;

    logic       Clk;
    logic       Reset;
    logic       CharLoad;
    logic [7:0] VData;
    logic       HSync;
    logic       FSync;
`ifdef SEMI4_BLANK_EN
    logic       DispEn;
`endif
    logic [7:0] S4Data;
    logic [3:0] S4Colour;
    logic       S4Valid;
    logic [3:0] Row;

    int total = 0;
    int bad   = 0;

    semi4_gen dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .CharLoad (CharLoad),
        .VData    (VData),
        .HSync    (HSync),
        .FSync    (FSync),
`ifdef SEMI4_BLANK_EN
        .DispEn   (DispEn),
`endif
        .S4Data   (S4Data),
        .S4Colour (S4Colour),
        .S4Valid  (S4Valid),
        .Row      (Row)
    );

    // Free-running pixel clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive inputs, let one rising edge pass, return on the falling edge
    task automatic applyStimulus(input logic rst, input logic cl,
                                 input logic [7:0] vd, input logic hs,
                                 input logic fs);
        Reset    = rst;
        CharLoad = cl;
        VData    = vd;
        HSync    = hs;
        FSync    = fs;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // One full HSync pulse: high for a cycle, then low for a cycle
    task automatic hsPulse();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic checkRow(input string tag, input logic [3:0] r);
        total++;
        assert (Row === r) else begin
            bad++;
            $error("[TB] FAIL %s row got=%0d want=%0d", tag, Row, r);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] d,
                               input logic [3:0] c, input logic v,
                               input logic [3:0] r);
        total++;
        assert (S4Data === d) else begin
            bad++;
            $error("[TB] FAIL %s data got=%h want=%h", tag, S4Data, d);
        end
        total++;
        assert (S4Colour === c) else begin
            bad++;
            $error("[TB] FAIL %s colour got=%h want=%h", tag, S4Colour, c);
        end
        total++;
        assert (S4Valid === v) else begin
            bad++;
            $error("[TB] FAIL %s valid got=%b want=%b", tag, S4Valid, v);
        end
        checkRow(tag, r);
    endtask

    initial begin
`ifdef SEMI4_BLANK_EN
        DispEn = 1'b1;
`endif
        // Reset held for two cycles while a load is requested
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("reset1", 8'h00, 4'h0, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("reset2", 8'h00, 4'h0, 1'b0, 4'd0);

        // Field sync, then an upper-half load
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkRow("fsync_clear", 4'd0);
        applyStimulus(1'b0, 1'b1, 8'hB9, 1'b0, 1'b0);
        checkOutput("upper_b9", 8'hF0, 4'h3, 1'b1, 4'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("hold_b9", 8'hF0, 4'h3, 1'b0, 4'd0);

        // Five pulses, then a sixth edge held high for three cycles
        for (int i = 0; i < 5; i++) hsPulse();
        checkRow("row5", 4'd5);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkRow("held_high", 4'd6);
        applyStimulus(1'b0, 1'b1, 8'hB9, 1'b0, 1'b0);
        checkOutput("lower_b9", 8'h0F, 4'h3, 1'b1, 4'd6);

        // Full wrap of twelve edges from row 0
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) hsPulse();
        checkRow("row11", 4'd11);
        hsPulse();
        checkRow("wrap0", 4'd0);

        // Field sync wins over a coincident line edge
        for (int i = 0; i < 5; i++) hsPulse();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkRow("fsync_prio", 4'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Load coincident with the edge leaving row 5 samples row 5
        for (int i = 0; i < 5; i++) hsPulse();
        applyStimulus(1'b0, 1'b1, 8'h8C, 1'b1, 1'b0);
        checkOutput("coincident_8c", 8'hFF, 4'h0, 1'b1, 4'd6);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Load coincident with field sync samples the old row 6 (lower half)
        applyStimulus(1'b0, 1'b1, 8'hF2, 1'b0, 1'b1);
        checkOutput("fsync_load_f2", 8'hF0, 4'h7, 1'b1, 4'd0);

        // Alphanumeric byte still pulses valid but yields an empty cell
        applyStimulus(1'b0, 1'b1, 8'h4F, 1'b0, 1'b0);
        checkOutput("alpha_4f", 8'h00, 4'h0, 1'b1, 4'd0);

        // Back-to-back loads each give their own update
        applyStimulus(1'b0, 1'b1, 8'hB9, 1'b0, 1'b0);
        checkOutput("b2b_first", 8'hF0, 4'h3, 1'b1, 4'd0);
        applyStimulus(1'b0, 1'b1, 8'hC5, 1'b0, 1'b0);
        checkOutput("b2b_second", 8'h0F, 4'h4, 1'b1, 4'd0);

        // Reset mid-line discards the coincident load and clears the row
        hsPulse();
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("reset_mid", 8'h00, 4'h0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("after_reset", 8'h00, 4'h0, 1'b0, 4'd0);

`ifdef SEMI4_BLANK_EN
        // Blanking forces an empty cell without touching the row
        DispEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("blank_ff", 8'h00, 4'h0, 1'b1, 4'd0);
        DispEn = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("unblank_ff", 8'hFF, 4'h7, 1'b1, 4'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
